// File: rtl/cpu_pkg.sv
// Shared encodings for the PC control slice.
// Op codes and FSM state values.
package cpu_pkg;

  typedef logic [2:0] op_t;
  typedef logic [1:0] st_t;

  localparam op_t OP_NOP  = 3'd0;
  localparam op_t OP_JMP  = 3'd1;
  localparam op_t OP_JZ   = 3'd2;
  localparam op_t OP_CALL = 3'd3;
  localparam op_t OP_RET  = 3'd4;
  localparam op_t OP_LDB  = 3'd5;
  localparam op_t OP_HLT  = 3'd6;

  localparam st_t ST_RUN   = 2'd0;
  localparam st_t ST_HALT  = 2'd1;
  localparam st_t ST_FAULT = 2'd2;

endpackage

// File: rtl/cpu_pc_stack.sv
// Return-address LIFO for CALL/RET.
// DOUT always shows the top entry.
module cpu_pc_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int PW = $clog2(STACK_DEPTH);

  logic [PW:0]       sp;
  logic [PW-1:0]     top;
  logic [WIDTH-1:0]  mem [STACK_DEPTH];

  assign top   = sp[PW-1:0] - PW'(1);
  assign FULL  = (sp == (PW+1)'(STACK_DEPTH));
  assign EMPTY = (sp == '0);
  assign DOUT  = mem[top];

  // Stack pointer: count of valid entries.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      sp <= '0;
    else if (PUSH && !FULL)
      sp <= sp + 1'b1;
    else if (POP && !EMPTY)
      sp <= sp - 1'b1;
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge CLK) begin
    if (RST_N && PUSH && !FULL)
      mem[sp[PW-1:0]] <= DIN;
  end

endmodule

// File: rtl/cpu_pc_ctrl.sv
// Program counter sequencer with return stack.
// RUN/HALT/FAULT FSM; jump target from external unit.
module cpu_pc_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             STALL,
  input  logic [2:0]       OP,
  input  logic             MODE,
  input  logic [WIDTH-1:0] ARG,
  input  logic             ZERO_FLAG,
  input  logic             RESUME,
  input  logic [WIDTH-1:0] JMP_ADDR,
  output logic             JMP_MODE,
  output logic [WIDTH-1:0] BASE_REG_OFFSET,
  output logic             BASE_REG_LD,
  output logic [WIDTH-1:0] BASE_REG_DATA,
  output logic [WIDTH-1:0] PC,
  output logic             HALTED,
  output logic             FAULT
);

  st_t              state, st_nxt;
  logic [WIDTH-1:0] pc_nxt, pc_inc;
  logic [WIDTH-1:0] stk_dout;
  logic             stk_full, stk_empty;
  logic             push, pop;
  logic             active;

  assign JMP_MODE        = MODE;
  assign BASE_REG_OFFSET = ARG;
  assign BASE_REG_DATA   = ARG;

  assign HALTED = (state == ST_HALT);
  assign FAULT  = (state == ST_FAULT);

  assign active = RST_N && (state == ST_RUN) && !STALL;
  assign pc_inc = PC + 1'b1;

  assign BASE_REG_LD = active && (OP == OP_LDB);

  cpu_pc_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .CLK   (CLK),
    .RST_N (RST_N),
    .PUSH  (push),
    .POP   (pop),
    .DIN   (pc_inc),
    .DOUT  (stk_dout),
    .FULL  (stk_full),
    .EMPTY (stk_empty)
  );

  // Next PC, next state and stack strobes.
  always_comb begin
    pc_nxt = PC;
    st_nxt = state;
    push   = 1'b0;
    pop    = 1'b0;
    if (state == ST_HALT) begin
      if (RESUME)
        st_nxt = ST_RUN;
    end else if (active) begin
      unique case (1'b1)
        (OP == OP_JMP): pc_nxt = JMP_ADDR;
        (OP == OP_JZ):  pc_nxt = ZERO_FLAG ? JMP_ADDR : pc_inc;
        (OP == OP_CALL): begin
          if (stk_full) begin
            st_nxt = ST_FAULT;
          end else begin
            push   = 1'b1;
            pc_nxt = JMP_ADDR;
          end
        end
        (OP == OP_RET): begin
          if (stk_empty) begin
            st_nxt = ST_FAULT;
          end else begin
            pop    = 1'b1;
            pc_nxt = stk_dout;
          end
        end
        (OP == OP_HLT): begin
          pc_nxt = pc_inc;
          st_nxt = ST_HALT;
        end
        default: pc_nxt = pc_inc;
      endcase
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PC    <= '0;
      state <= ST_RUN;
    end else begin
      PC    <= pc_nxt;
      state <= st_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_pc_ctrl.sv
// Bench for cpu_pc_ctrl: directed scenarios plus
// random ops against a queue-based reference model.
module tb_cpu_pc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [2:0] op;
  logic       mode;
  logic [7:0] arg;
  logic       zero_flag;
  logic       resume;
  logic [7:0] jmp_addr;
  logic       jmp_mode;
  logic [7:0] base_reg_offset;
  logic       base_reg_ld;
  logic [7:0] base_reg_data;
  logic [7:0] pc;
  logic       halted;
  logic       fault;

  int vectors = 0;
  int errors  = 0;

  // Reference model: 0=run, 1=halt, 2=fault.
  logic [7:0] m_pc;
  logic [7:0] m_base;
  logic [7:0] m_stack[$];
  int         m_state;
  logic       exp_ld;
  logic       got_ld;

  always #5 clk = ~clk;

  cpu_pc_ctrl dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .STALL           (stall),
    .OP              (op),
    .MODE            (mode),
    .ARG             (arg),
    .ZERO_FLAG       (zero_flag),
    .RESUME          (resume),
    .JMP_ADDR        (jmp_addr),
    .JMP_MODE        (jmp_mode),
    .BASE_REG_OFFSET (base_reg_offset),
    .BASE_REG_LD     (base_reg_ld),
    .BASE_REG_DATA   (base_reg_data),
    .PC              (pc),
    .HALTED          (halted),
    .FAULT           (fault)
  );

  // One clock: drive, sample strobe, advance model.
  task automatic step(input logic r, input logic s,
                      input logic [2:0] o, input logic md,
                      input logic [7:0] a, input logic z,
                      input logic rs);
    logic [7:0] tgt;
    logic [7:0] nxt;
    rst_n     = r;
    stall     = s;
    op        = o;
    mode      = md;
    arg       = a;
    zero_flag = z;
    resume    = rs;
    tgt       = md ? 8'(m_base + a) : a;
    jmp_addr  = tgt;
    @(negedge clk);
    got_ld = base_reg_ld;
    exp_ld = 1'b0;
    nxt    = m_pc + 8'd1;
    if (!r) begin
      m_pc    = 8'h00;
      m_state = 0;
      m_stack.delete();
    end else if (m_state == 1) begin
      if (rs) m_state = 0;
    end else if (m_state == 0 && !s) begin
      case (o)
        3'd1: m_pc = tgt;
        3'd2: m_pc = z ? tgt : nxt;
        3'd3: begin
          if (m_stack.size() == 4) m_state = 2;
          else begin
            m_stack.push_back(nxt);
            m_pc = tgt;
          end
        end
        3'd4: begin
          if (m_stack.size() == 0) m_state = 2;
          else m_pc = m_stack.pop_back();
        end
        3'd5: begin
          exp_ld = 1'b1;
          m_base = a;
          m_pc   = nxt;
        end
        3'd6: begin
          m_pc    = nxt;
          m_state = 1;
        end
        default: m_pc = nxt;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic md,
                        input logic [7:0] a);
    step(1'b1, 1'b0, o, md, a, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 3'd3, 1'b1, 8'h55, 1'b1, 1'b1);
    vectors++;
    if (pc !== 8'h00 || halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h h=%b f=%b want 00 0 0",
               pc, halted, fault);
    end
    vectors++;
    if (got_ld !== 1'b0) begin
      errors++;
      $display("FAIL reset_ld: got %b want 0", got_ld);
    end
  endtask

  task automatic test_nop_wrap();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      run_op(3'd0, 1'b0, 8'h00);
      vectors++;
      if (pc !== 8'(i)) begin
        errors++;
        $display("FAIL nop_%0d: pc=%h want %h", i, pc, 8'(i));
      end
    end
    run_op(3'd1, 1'b0, 8'hFF);
    run_op(3'd7, 1'b0, 8'h00);
    vectors++;
    if (pc !== 8'h00) begin
      errors++;
      $display("FAIL wrap: pc=%h want 00", pc);
    end
  endtask

  task automatic test_ldb_jmp();
    do_reset();
    run_op(3'd5, 1'b0, 8'h40);
    vectors++;
    if (got_ld !== 1'b1 || pc !== 8'h01) begin
      errors++;
      $display("FAIL ldb: ld=%b pc=%h want 1 01", got_ld, pc);
    end
    run_op(3'd1, 1'b1, 8'h05);
    vectors++;
    if (got_ld !== 1'b0 || pc !== 8'h45) begin
      errors++;
      $display("FAIL jmp_base: ld=%b pc=%h want 0 45", got_ld, pc);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    run_op(3'd1, 1'b0, 8'h10);
    run_op(3'd3, 1'b0, 8'h80);
    vectors++;
    if (pc !== 8'h80) begin
      errors++;
      $display("FAIL call: pc=%h want 80", pc);
    end
    run_op(3'd4, 1'b1, 8'h33);
    vectors++;
    if (pc !== 8'h11 || fault !== 1'b0) begin
      errors++;
      $display("FAIL ret: pc=%h f=%b want 11 0", pc, fault);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++)
      run_op(3'd3, 1'b0, 8'(8'h20 + i * 16));
    vectors++;
    if (pc !== 8'h50 || fault !== 1'b0) begin
      errors++;
      $display("FAIL call4: pc=%h f=%b want 50 0", pc, fault);
    end
    run_op(3'd3, 1'b0, 8'hAA);
    vectors++;
    if (pc !== 8'h50 || fault !== 1'b1) begin
      errors++;
      $display("FAIL call5: pc=%h f=%b want 50 1", pc, fault);
    end
    run_op(3'd4, 1'b0, 8'h00);
    step(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (pc !== 8'h50 || fault !== 1'b1) begin
      errors++;
      $display("FAIL sticky: pc=%h f=%b want 50 1", pc, fault);
    end
    do_reset();
    run_op(3'd4, 1'b0, 8'h00);
    vectors++;
    if (pc !== 8'h00 || fault !== 1'b1) begin
      errors++;
      $display("FAIL underflow: pc=%h f=%b want 00 1", pc, fault);
    end
  endtask

  task automatic test_jz_stall();
    do_reset();
    run_op(3'd1, 1'b0, 8'h30);
    step(1'b1, 1'b0, 3'd2, 1'b0, 8'h90, 1'b0, 1'b0);
    vectors++;
    if (pc !== 8'h31) begin
      errors++;
      $display("FAIL jz_nt: pc=%h want 31", pc);
    end
    step(1'b1, 1'b0, 3'd2, 1'b0, 8'h90, 1'b1, 1'b0);
    vectors++;
    if (pc !== 8'h90) begin
      errors++;
      $display("FAIL jz_t: pc=%h want 90", pc);
    end
    for (int o = 0; o < 8; o++) begin
      step(1'b1, 1'b1, 3'(o), 1'b0, 8'h12, 1'b1, 1'b0);
      vectors++;
      if (pc !== 8'h90 || got_ld !== 1'b0) begin
        errors++;
        $display("FAIL stall_op%0d: pc=%h ld=%b want 90 0",
                 o, pc, got_ld);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    run_op(3'd1, 1'b0, 8'h20);
    run_op(3'd6, 1'b0, 8'h00);
    vectors++;
    if (pc !== 8'h21 || halted !== 1'b1) begin
      errors++;
      $display("FAIL hlt: pc=%h h=%b want 21 1", pc, halted);
    end
    run_op(3'd1, 1'b0, 8'hEE);
    run_op(3'd5, 1'b0, 8'h01);
    vectors++;
    if (pc !== 8'h21 || halted !== 1'b1 || got_ld !== 1'b0) begin
      errors++;
      $display("FAIL hlt_hold: pc=%h h=%b ld=%b want 21 1 0",
               pc, halted, got_ld);
    end
    step(1'b1, 1'b1, 3'd1, 1'b0, 8'hEE, 1'b0, 1'b1);
    vectors++;
    if (pc !== 8'h21 || halted !== 1'b0) begin
      errors++;
      $display("FAIL resume: pc=%h h=%b want 21 0", pc, halted);
    end
    run_op(3'd0, 1'b0, 8'h00);
    vectors++;
    if (pc !== 8'h22) begin
      errors++;
      $display("FAIL post_resume: pc=%h want 22", pc);
    end
    run_op(3'd6, 1'b0, 8'h00);
    do_reset();
    vectors++;
    if (pc !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL hlt_reset: pc=%h h=%b want 00 0", pc, halted);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      o = 3'($urandom_range(0, 7));
      if (o == 3'd6 && $urandom_range(0, 2) != 0) o = 3'd0;
      step(($urandom_range(0, 40) != 0),
           ($urandom_range(0, 5) == 0),
           o, 1'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0));
      vectors++;
      if (pc !== m_pc || halted !== (m_state == 1) ||
          fault !== (m_state == 2) || got_ld !== exp_ld) begin
        errors++;
        $display("FAIL rand_%0d: pc=%h h=%b f=%b ld=%b want %h %b %b %b",
                 i, pc, halted, fault, got_ld, m_pc,
                 m_state == 1, m_state == 2, exp_ld);
      end
      vectors++;
      if (jmp_mode !== mode || base_reg_offset !== arg ||
          base_reg_data !== arg) begin
        errors++;
        $display("FAIL passthru_%0d: m=%b off=%h dat=%h want %b %h",
                 i, jmp_mode, base_reg_offset, base_reg_data,
                 mode, arg);
      end
    end
  endtask

  initial begin
    m_pc    = 8'h00;
    m_base  = 8'h00;
    m_state = 0;
    test_reset();
    test_nop_wrap();
    test_ldb_jmp();
    test_call_ret();
    test_overflow();
    test_jz_stall();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
